// File: rtl/chaos_pkg.sv
// Shared definitions for the chaotic map generator: mode encoding, FSM states
// and width-generic fixed-point constants.
package chaos_pkg;

    localparam logic MODE_TENT     = 1'b0;
    localparam logic MODE_LOGISTIC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL1,
        ST_MUL2,
        ST_EMIT
    } state_t;

    localparam int MAX_W = 64;

    // Q0.w constants built at the widest width; users truncate to their own W.
    function automatic logic [MAX_W-1:0] one_half(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [MAX_W-1:0] all_ones(input int w);
        return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction

endpackage

// File: rtl/chaos_mul.sv
// Registered unsigned W x W multiplier with MUL_LAT pipeline stages.
// No enable or reset: the controlling FSM simply ignores results it does not want.
module chaos_mul #(
    parameter int W       = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   p
);

    logic [2*W-1:0] prod_p [MUL_LAT];

    // Stage 0 forms the product; later stages only delay it.
    always_ff @(posedge clk) begin
        prod_p[0] <= (2*W)'(a) * (2*W)'(b);
        for (int i = 1; i < MUL_LAT; i++) begin
            prod_p[i] <= prod_p[i-1];
        end
    end

    assign p = prod_p[MUL_LAT-1];

endmodule

// File: rtl/chaos_map_gen.sv
// Multi-channel tent/logistic chaotic sequence generator sharing one pipelined
// fixed-point multiplier; channels are served round-robin onto a valid/ready stream.
module chaos_map_gen
    import chaos_pkg::*;
#(
    parameter int             W         = 32,
    parameter int             NCH       = 4,
    parameter int             MUL_LAT   = 2,
    parameter logic [W-1:0]   SEED      = W'(32'h52B020C5),
    parameter logic [W-1:0]   SEED_STEP = W'(32'h01000000),
    localparam int            PW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [W-1:0]     mu,
    input  logic [31:0]      num_samples,
    input  logic             seed_we,
    input  logic [PW-1:0]    seed_ch,
    input  logic [W-1:0]     seed_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [PW-1:0]    out_ch,
    output logic             busy,
    output logic             done
);

    localparam int           LW       = $clog2(MUL_LAT + 1);
    localparam logic [W-1:0] ONE_HALF = W'(one_half(W));
    localparam logic [W-1:0] ALL_ONES = W'(all_ones(W));

    state_t          state, state_nxt;
    logic [W-1:0]    x_mem [NCH];
    logic [PW-1:0]   ptr;
    logic [31:0]     cnt, num_lat;
    logic            mode_lat;
    logic [W-1:0]    mu_lat;
    logic [LW-1:0]   lat_cnt;
    logic [W-1:0]    x_cur, onem, t_val, y_val, mul_a, mul_b;
    logic [2*W-1:0]  mul_p;
    logic            last_lat, y_take, commit, done_nxt;

    // 1 - x in Q0.W; x = 0 would need 2^W, so it clamps to the largest value.
    function automatic logic [W-1:0] one_minus(input logic [W-1:0] v);
        return (v == '0) ? ALL_ONES : (~v + W'(1));
    endfunction

    // Q2.(2W-2) product back to Q0.W; anything at or above 1.0 saturates.
    function automatic logic [W-1:0] sat_result(input logic [2*W-1:0] p);
        return (p[2*W-1 -: 2] != 2'b00) ? ALL_ONES : p[2*W-3 -: W];
    endfunction

    chaos_mul #(.W(W), .MUL_LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    always_comb begin
        x_cur    = x_mem[ptr];
        onem     = one_minus(x_cur);
        t_val    = mul_p[2*W-1 -: W];
        y_val    = sat_result(mul_p);
        last_lat = (lat_cnt == LW'(MUL_LAT - 1));
        y_take   = last_lat && ((state == ST_MUL1 && mode_lat == MODE_TENT) || state == ST_MUL2);
        // Default operands are the logistic second pass (mu * x(1-x)).
        mul_a    = mu_lat;
        mul_b    = t_val;
        if (state == ST_LOAD) begin
            if (mode_lat == MODE_LOGISTIC) begin
                mul_a = x_cur;
                mul_b = onem;
            end else begin
                mul_b = (x_cur < ONE_HALF) ? x_cur : onem;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_MUL1;
            ST_MUL1: if (last_lat) state_nxt = (mode_lat == MODE_TENT) ? ST_EMIT : ST_MUL2;
            ST_MUL2: if (last_lat) state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (out_ready) begin
                    commit = 1'b1;
                    if (num_lat != 32'd0 && cnt + 32'd1 == num_lat) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // abort wins over a same-cycle handshake: nothing is committed.
        if (abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            commit    = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            if ((state == ST_MUL1 || state == ST_MUL2) && !last_lat) lat_cnt <= lat_cnt + 1'b1;
            else lat_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) x_mem[c] <= SEED + W'(c) * SEED_STEP;
            ptr      <= '0;
            cnt      <= '0;
            num_lat  <= '0;
            mode_lat <= MODE_TENT;
            mu_lat   <= '0;
            out_data <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (seed_we) x_mem[seed_ch] <= seed_data;
                if (start) begin
                    mode_lat <= mode;
                    mu_lat   <= mu;
                    num_lat  <= num_samples;
                    cnt      <= '0;
                    ptr      <= '0;
                end
            end
            if (y_take) out_data <= y_val;
            if (commit) begin
                x_mem[ptr] <= out_data;
                ptr        <= (NCH == 1) ? '0 : ptr + 1'b1;
                cnt        <= cnt + 32'd1;
            end
        end
    end

    assign out_valid = (state == ST_EMIT);
    assign out_ch    = ptr;
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/chaos_map_gen.md
Name: chaos_map_gen

Overview:
Parametrised, multi-channel fixed-point chaotic sequence generator supporting tent and logistic maps. Replaces float-core plus delay-counter sequencing with one shared pipelined fixed-point multiplier. NCH channel states are time-multiplexed round-robin. Samples leave on a valid/ready stream consumed by the UART or RAM writer.

Parameters:
W, 32, datapath width; x is unsigned Q0.W, mu is unsigned Q2.(W-2)
NCH, 4, number of independent channels (power of 2, >=1)
MUL_LAT, 2, multiplier pipeline latency in cycles (>=1)
SEED, 32'h52B020C5, reset seed of channel 0 (about 0.323)
SEED_STEP, 32'h01000000, reset seed increment per channel (x[c] = SEED + c*SEED_STEP, mod 2^W)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begin run (accepted only in IDLE)
abort  in  1  pulse; stop run, return to IDLE
mode  in  1  0 = tent, 1 = logistic; sampled at start
mu  in  W  map parameter, Q2.(W-2); sampled at start
num_samples  in  32  total samples to emit across all channels; 0 = unbounded
seed_we  in  1  write seed (honoured only in IDLE)
seed_ch  in  clog2(NCH)  seed target channel
seed_data  in  W  seed value, Q0.W
out_valid  out  1  sample available
out_ready  in  1  consumer accepts
out_data  out  W  new x value, Q0.W
out_ch  out  clog2(NCH)  channel of out_data
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse after final handshake of a bounded run

Behaviour:
- Reset: state IDLE; out_valid=0, out_data=0, out_ch=0, busy=0, done=0; channel pointer=0; sample counter=0; x[c]=SEED+c*SEED_STEP. Reset mid-run discards everything, including a pending sample.
- States: IDLE, LOAD, MUL1, MUL2, EMIT.
- IDLE: seed_we writes x[seed_ch]. start latches mode, mu and num_samples, clears counter, sets pointer=0, goes to LOAD. start together with seed_we: seed is written first, then the run starts using it.
- LOAD (1 cycle): onem = 2^W - x when x != 0, else all-ones.
  - Tent: a = (x < 2^(W-1)) ? x : onem.
  - Logistic: a = x, with onem as second operand.
  - Operands go to the multiplier; next state is MUL1.
- MUL1 (MUL_LAT cycles, counted by a latency counter):
  - Tent: p = mu*a (2W bits, Q2.(2W-2)).
  - Logistic: t = (x*onem)[2W-1:W] (Q0.W), then issue mu*t and go to MUL2 for MUL_LAT cycles.
- Result: y = p[2W-3:W-2]. If p[2W-1:2W-2] != 0, saturate y to all-ones.
- EMIT: out_valid=1, out_data=y, out_ch=pointer. Data and channel stay stable while valid and not ready. On handshake:
  - x[pointer]=y; pointer increments mod NCH; counter increments.
  - If num_samples != 0 and counter reaches num_samples: pulse done, go to IDLE.
  - Otherwise go to LOAD.
- Latency: with start sampled at cycle 0, out_valid rises at cycle 2+MUL_LAT (tent) or 2+2*MUL_LAT (logistic). Throughput is 1 sample per (2+MUL_LAT) or (2+2*MUL_LAT) cycles with out_ready held high.
- abort: any non-IDLE state goes to IDLE next edge; out_valid drops; no done; x[] keeps its last committed values. abort beats a same-cycle handshake: that sample is not committed.
- start and seed_we are ignored while busy. mode and mu changes mid-run have no effect.
- x=0 is a fixed point and is emitted as-is; no escape logic.
- Counter wraps at 2^32 in unbounded mode.

Decomposition:
- Shared package chaos_pkg holds the mode encoding (MODE_TENT=0, MODE_LOGISTIC=1), the FSM state enum, and the fixed-point helper constants (ONE_HALF, ALL_ONES as width-generic expressions).
- One sub-module, chaos_mul: registered W x W unsigned multiplier with MUL_LAT pipeline stages and 2W-bit output. It has no clock enable and no aclr; it is reset by the parent FSM ignoring its output.

Test Plan:
- W=32, NCH=1, MUL_LAT=2, tent, mu=32'h80000000 (2.0), seed 32'h40000000, num_samples=3, out_ready=1 -> out_data 32'h80000000, 32'hFFFFFFFF (saturated), 32'h00000002; done pulses once; first out_valid at cycle 4.
- Logistic, mu=32'h80000000, seed 32'h80000000, num_samples=2 -> out_data 32'h80000000 twice; first out_valid at cycle 6.
- NCH=4, tent, seeds 0x40000000/0x20000000/0x10000000/0x08000000, mu=2.0, num_samples=4 -> out_ch 0,1,2,3 with out_data 0x80000000, 0x40000000, 0x20000000, 0x10000000.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT -> out_valid, out_data and out_ch stable; exactly one commit after ready rises.
- abort in MUL1, then restart -> no output, no done; first sample recomputed from the unchanged seed.
- reset asserted in EMIT -> next cycle out_valid=0, busy=0; x[0] reads back SEED on the next run.
